imm_gen_pipe: RTL

Parametrised, pipelined immediate generator for the next-generation (pipelined) core. It decodes all five RV immediate formats (I/S/B/U/J), sign-extends to XLEN, and tags each result. It buffers results in a small FIFO behind a valid/ready handshake. It sits between the decode-stage instruction register and the execute-stage operand mux, replacing the single-cycle combinational extender.

---
 rtl/imm_pkg.sv | 16 +
 rtl/imm_decode.sv | 30 +++
 rtl/imm_gen_pipe.sv | 94 +++++++++
 3 files changed

// File: rtl/imm_pkg.sv
// Shared definitions for the pipelined immediate generator: the imm_src format
// codes, which match the single-cycle extender encoding.
package imm_pkg;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  // Bits one FIFO entry needs: immediate, tag and illegal flag.
  function automatic int entry_w(input int xlen, input int tag_w);
    return xlen + tag_w + 1;
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational RV immediate format mux and sign extender. It has no state, so
// the single-cycle core can reuse it as is.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     instr,
  input  logic [2:0]      imm_src,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  // Each format is built as a signed field and then widened with a size cast.
  // The cast sign-extends, which also fills the upper word of U for XLEN=64.
  always_comb begin
    // NOTE: assign every output a default first so no path through the case infers a latch.
    imm     = '0;
    illegal = 1'b0;
    case (imm_src)
      IMM_I: imm = XLEN'($signed(instr[31:20]));
      IMM_S: imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      IMM_B: imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      IMM_U: imm = XLEN'($signed({instr[31:12], 12'b0}));
      IMM_J: imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decodes on accept into a small FIFO, presents
// the head behind a valid/ready handshake and counts illegal formats.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      instr,
  input  logic [2:0]       imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_ext,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal,
  output logic [7:0]       illegal_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           hold_q;
  entry_t           head;
  entry_t           new_entry;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic [7:0]       illegal_q;
  logic [XLEN-1:0]  dec_imm;
  logic             dec_illegal;
  logic             accept, pop;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr   (instr),
    .imm_src (imm_src),
    .imm     (dec_imm),
    .illegal (dec_illegal)
  );

  assign in_ready  = (count < CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign new_entry = '{imm: dec_imm, tag: in_tag, illegal: dec_illegal};

  // When the FIFO is empty the outputs keep showing the last popped entry.
  assign head        = out_valid ? mem[rd_ptr] : hold_q;
  assign imm_ext     = head.imm;
  assign out_tag     = head.tag;
  assign out_illegal = head.illegal;
  assign illegal_cnt = illegal_q;

  // NOTE: storage is not reset; count gates every read of it, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= new_entry;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      hold_q    <= '0;
      illegal_q <= '0;
    end else begin
      if (accept && DEPTH > 1) wr_ptr <= wr_ptr + 1'b1;
      if (pop && DEPTH > 1)    rd_ptr <= rd_ptr + 1'b1;
      if (pop)                 hold_q <= head;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (accept && dec_illegal && illegal_q != 8'hFF) illegal_q <= illegal_q + 8'd1;
    end
  end

  logic unused_pkg;
  assign unused_pkg = (entry_w(XLEN, TAG_W) != $bits(entry_t));

endmodule
